// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver handshake plus CPU-side byte-read port of the UART RX FIFO.
interface uart_rx_fifo_if #(parameter int DEPTH = 4);
    localparam int AW = $clog2(DEPTH);
    logic          rx_data_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic [1:0]    rx_ctrl;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          clr_overrun;
    logic          uart_idle;
    modport master (
        output rx_data_valid, rx_data, rx_ready, rd_en, clr_overrun,
        input  rx_ctrl, rd_data, rd_valid, empty, full, count, overrun, uart_idle
    );
    modport slave (
        input  rx_data_valid, rx_data, rx_ready, rd_en, clr_overrun,
        output rx_ctrl, rd_data, rd_valid, empty, full, count, overrun, uart_idle
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures receiver bytes into a DEPTH-entry FIFO and drives the finish/re-arm handshake.
module uart_rx_fifo #(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 64
) (
    input logic           clk,
    input logic           rst,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [7:0]  TMO_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {WAIT, CAPTURE, ACK, REARM1, REARM2, GAP} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt;
    logic [7:0]      tcnt;
    logic            rd_acc;
    logic            wr_req;
    logic            wr_acc;
    logic            drop;

    // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
    always_comb begin
        rd_acc = bus.rd_en && cnt != '0;
        wr_req = state == WAIT && bus.rx_data_valid;
        wr_acc = wr_req && (cnt != FULL_CNT || rd_acc);
        drop   = wr_req && !wr_acc;
    end

    assign bus.empty = cnt == '0;
    assign bus.full  = cnt == FULL_CNT;
    assign bus.count = cnt;

    always_ff @(posedge clk)
        if (rst && wr_acc) mem[wr_ptr] <= bus.rx_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            bus.rd_data <= 8'h00;
            bus.rd_valid <= 1'b0;
            bus.overrun <= 1'b0;
            bus.uart_idle <= 1'b0;
        end else begin
            bus.uart_idle <= bus.rx_ready;
            bus.rd_valid  <= rd_acc;
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr      <= rd_ptr + 1'b1;
                bus.rd_data <= mem[rd_ptr];
            end
            cnt <= cnt + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
            bus.overrun <= drop ? 1'b1 : (bus.clr_overrun ? 1'b0 : bus.overrun);
        end
    end

    // rx_ctrl is loaded with the value belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= WAIT;
            bus.rx_ctrl <= 2'b00;
            tcnt        <= '0;
        end else begin
            case (state)
                WAIT: if (bus.rx_data_valid) begin
                    state       <= CAPTURE;
                    bus.rx_ctrl <= 2'b10;
                end
                CAPTURE: begin
                    state <= ACK;
                    tcnt  <= '0;
                end
                ACK: if (!bus.rx_data_valid || tcnt == TMO_LAST) begin
                    state       <= REARM1;
                    bus.rx_ctrl <= 2'b01;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                REARM1: state <= REARM2;
                REARM2: begin
                    state       <= GAP;
                    bus.rx_ctrl <= 2'b00;
                end
                GAP: state <= WAIT;
                default: begin
                    state       <= WAIT;
                    bus.rx_ctrl <= 2'b00;
                end
            endcase
        end
    end
endmodule
